comma_word_aligner: RTL and testbench

- Single-clock serial-to-parallel front end for the SerDes receive path; runs on the fast bit clock.
- Shifts in one serial bit per qualified cycle and hunts for the 8b/10b K28.5 comma in either disparity.
- Locks symbol alignment to the comma and emits aligned SYM_WIDTH-bit symbols with a valid strobe.
- Feeds the 10b-to-8b decoder and the clock-crossing FIFO; replaces the fixed-phase bit collector.

---
 rtl/serdes_pkg.sv | 10 +
 rtl/comma_detect.sv | 15 +
 rtl/comma_word_aligner.sv | 119 +++++++++++
 tb/tb_comma_word_aligner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared SerDes receive constants and the word aligner state type.
package serdes_pkg;

    localparam int SYM_WIDTH = 10;
    localparam logic [9:0] K28_5_RDN = 10'b0101111100;
    localparam logic [9:0] K28_5_RDP = 10'b1010000011;

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} align_state_t;

endpackage

// File: rtl/comma_detect.sv
// comma_detect: flags a symbol-wide word equal to either comma disparity.
module comma_detect
    import serdes_pkg::*;
#(
    parameter int W = SYM_WIDTH,
    parameter logic [W-1:0] COMMA_N = K28_5_RDN,
    parameter logic [W-1:0] COMMA_P = K28_5_RDP
) (
    input  logic [W-1:0] word,
    output logic         match
);

    assign match = (word == COMMA_N) || (word == COMMA_P);

endmodule

// File: rtl/comma_word_aligner.sv
// comma_word_aligner: bit-serial deserializer that locks symbol framing to the K28.5 comma.
module comma_word_aligner #(
    parameter int SYM_WIDTH = serdes_pkg::SYM_WIDTH,
    parameter logic [SYM_WIDTH-1:0] COMMA_N = serdes_pkg::K28_5_RDN,
    parameter logic [SYM_WIDTH-1:0] COMMA_P = serdes_pkg::K28_5_RDP,
    parameter int LOCK_COUNT = 3,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Bit_Valid,
    input  logic                 i_Ser_Data,
    output logic [SYM_WIDTH-1:0] o_Sym,
    output logic                 o_Sym_Valid,
    output logic                 o_Is_Comma,
    output logic                 o_Locked,
    output logic [CNT_WIDTH-1:0] o_Realign_Cnt
);

    import serdes_pkg::*;

    localparam int BW = $clog2(SYM_WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);

    align_state_t state;
    logic [SYM_WIDTH-1:0] sr;
    logic [SYM_WIDTH-1:0] sr_next;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] comma_cnt;
    logic [CW-1:0] comma_inc;
    logic [MW-1:0] mis_cnt;
    logic [MW-1:0] mis_inc;
    logic comma;
    logic boundary;

    assign sr_next = {i_Ser_Data, sr[SYM_WIDTH-1:1]};
    assign boundary = bit_cnt == BW'(SYM_WIDTH - 1);
    assign comma_inc = comma_cnt + 1'b1;
    assign mis_inc = mis_cnt + 1'b1;

    comma_detect #(
        .W(SYM_WIDTH),
        .COMMA_N(COMMA_N),
        .COMMA_P(COMMA_P)
    ) u_detect (
        .word(sr_next),
        .match(comma)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= HUNT;
            sr            <= '0;
            bit_cnt       <= '0;
            comma_cnt     <= '0;
            mis_cnt       <= '0;
            o_Sym         <= '0;
            o_Sym_Valid   <= 1'b0;
            o_Is_Comma    <= 1'b0;
            o_Locked      <= 1'b0;
            o_Realign_Cnt <= '0;
        end else begin
            o_Sym_Valid <= 1'b0;
            if (i_Bit_Valid) begin
                sr      <= sr_next;
                bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
                case (state)
                    HUNT: if (comma) begin
                        bit_cnt   <= '0;
                        comma_cnt <= CW'(1);
                        if (LOCK_COUNT == 1) begin
                            state       <= LOCKED;
                            o_Locked    <= 1'b1;
                            o_Sym       <= sr_next;
                            o_Sym_Valid <= 1'b1;
                            o_Is_Comma  <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: if (comma && boundary) begin
                        comma_cnt <= comma_inc;
                        if (comma_inc == CW'(LOCK_COUNT)) begin
                            state       <= LOCKED;
                            o_Locked    <= 1'b1;
                            o_Sym       <= sr_next;
                            o_Sym_Valid <= 1'b1;
                            o_Is_Comma  <= 1'b1;
                        end
                    end else if (comma) begin
                        bit_cnt   <= '0;
                        comma_cnt <= CW'(1);
                    end
                    LOCKED: if (boundary) begin
                        o_Sym       <= sr_next;
                        o_Sym_Valid <= 1'b1;
                        o_Is_Comma  <= comma;
                        if (comma) mis_cnt <= '0;
                    end else if (comma) begin
                        // off-phase commas only count; framing moves only after a full unlock
                        if (mis_inc == MW'(UNLOCK_COUNT)) begin
                            state     <= HUNT;
                            o_Locked  <= 1'b0;
                            mis_cnt   <= '0;
                            comma_cnt <= '0;
                            if (~&o_Realign_Cnt) o_Realign_Cnt <= o_Realign_Cnt + 1'b1;
                        end else begin
                            mis_cnt <= mis_inc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comma_word_aligner.sv
// tb_comma_word_aligner: randomized and directed checks of comma_word_aligner against a bit-history model.
module tb_comma_word_aligner;

    localparam logic [9:0] CN = 10'b0101111100;
    localparam logic [9:0] CP = 10'b1010000011;
    localparam int LOCK = 3;
    localparam int UNLOCK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_valid = 1'b0;
    logic ser_data = 1'b0;
    logic [9:0] sym;
    logic sym_valid, is_comma, locked;
    logic [7:0] realign_cnt;

    int cmps = 0;
    int errs = 0;

    // model: n counts valid bits, anchor is the bit index framing was last set on
    int n, anchor, st, cc, mc;
    logic [9:0] win, es;
    logic ev, ec, el;
    logic [7:0] erc;
    logic q[$];

    always #5 clk = ~clk;

    comma_word_aligner dut (
        .i_Clk(clk),
        .i_Rst_n(rst_n),
        .i_Bit_Valid(bit_valid),
        .i_Ser_Data(ser_data),
        .o_Sym(sym),
        .o_Sym_Valid(sym_valid),
        .o_Is_Comma(is_comma),
        .o_Locked(locked),
        .o_Realign_Cnt(realign_cnt)
    );

    function automatic logic [20:0] obs();
        return {sym_valid, sym_valid & is_comma, locked, realign_cnt, sym};
    endfunction

    function automatic logic [20:0] expv();
        return {ev, ev & ec, el, erc, es};
    endfunction

    task automatic model_reset();
        n = 0; anchor = 0; st = 0; cc = 0; mc = 0;
        win = '0; es = '0; ev = 1'b0; ec = 1'b0; el = 1'b0; erc = '0;
    endtask

    task automatic dut_reset();
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) q.push_back(w[i]);
    endtask

    task automatic build_lock_stream();
        q.delete();
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        push_word(CN); push_word(10'h2AA); push_word(CP); push_word(CN); push_word(10'h155);
    endtask

    task automatic step(input logic v, input logic d);
        logic c, b;
        bit_valid = v;
        ser_data = d;
        @(posedge clk);
        #1;
        ev = 1'b0;
        if (v) begin
            n++;
            win = {d, win[9:1]};
            c = (win == CN) || (win == CP);
            b = ((n - anchor) % 10) == 0;
            case (st)
                0: if (c) begin anchor = n; cc = 1; st = 1; end
                1: if (c && b) cc++; else if (c) begin anchor = n; cc = 1; end
                default: if (b) begin
                    ev = 1'b1; es = win; ec = c;
                    if (c) mc = 0;
                end else if (c) begin
                    mc++;
                    if (mc == UNLOCK) begin
                        st = 0; mc = 0; cc = 0;
                        if (erc != 8'hFF) erc++;
                    end
                end
            endcase
            if (st == 1 && cc == LOCK) begin
                st = 2; ev = 1'b1; es = win; ec = c;
            end
            el = st == 2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cmps++;
        if (obs() !== 21'd0) begin errs++; $display("FAIL por: got %h want 0", obs()); end
        rst_n = 1'b1;
        build_lock_stream();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, q[i]);
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL pre_reset[%0d]: got %h want %h", i, obs(), expv()); end
        end
        cmps++;
        if (locked !== 1'b1) begin errs++; $display("FAIL pre_reset_lock: got %b want 1", locked); end
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmps++;
        if (obs() !== 21'd0) begin errs++; $display("FAIL async_reset: got %h want 0", obs()); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'($urandom));
            cmps++;
            if (sym_valid !== 1'b0 || obs() !== expv()) begin
                errs++; $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_lock();
        dut_reset();
        build_lock_stream();
        for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL lock[%0d]: got %h want %h", i, obs(), expv()); end
            if (i == 41) begin
                cmps++;
                if (locked !== 1'b0) begin errs++; $display("FAIL lock_early: got %b want 0", locked); end
            end
            if (i == 42) begin
                cmps++;
                if ({locked, sym_valid, is_comma, sym} !== {3'b111, CN}) begin
                    errs++; $display("FAIL lock_rise: got %b%b%b %h want 111 %h", locked, sym_valid, is_comma, sym, CN);
                end
            end
            if (i == 52) begin
                cmps++;
                if ({sym_valid, sym} !== {1'b1, 10'h155}) begin
                    errs++; $display("FAIL lock_next: got %b %h want 1 155", sym_valid, sym);
                end
            end
        end
    endtask

    task automatic test_gapped();
        int cyc, last;
        logic [9:0] got[$];
        cyc = 0;
        last = -1;
        dut_reset();
        build_lock_stream();
        for (int i = 0; i < q.size(); i++) begin
            for (int j = 0; j < 5; j++) begin
                step(j == 4, (j == 4) ? q[i] : 1'($urandom));
                cyc++;
                cmps++;
                if (obs() !== expv()) begin errs++; $display("FAIL gapped[%0d.%0d]: got %h want %h", i, j, obs(), expv()); end
                if (sym_valid === 1'b1) begin
                    if (last >= 0) begin
                        cmps++;
                        if (cyc - last != 50) begin errs++; $display("FAIL gapped_spacing: got %0d want 50", cyc - last); end
                    end
                    last = cyc;
                    got.push_back(sym);
                end
            end
        end
        cmps++;
        if (got.size() != 2 || got[0] !== CN || got[1] !== 10'h155) begin
            errs++; $display("FAIL gapped_syms: got %0d symbols want 2 (%h %h)", got.size(), CN, 10'h155);
        end
    endtask

    task automatic test_bit_slip();
        dut_reset();
        q.delete();
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        push_word(CN); push_word(10'h2AA); push_word(CP); push_word(CN);
        q.push_back(1'b0);
        push_word(CP); push_word(CN); push_word(CP); push_word(CN);
        push_word(CN); push_word(CP); push_word(CN);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL slip[%0d]: got %h want %h", i, obs(), expv()); end
            if (i == 53 || i == 63 || i == 73) begin
                cmps++;
                if ({locked, realign_cnt} !== {1'b1, 8'd0}) begin
                    errs++; $display("FAIL slip_hold[%0d]: got %b %0d want 1 0", i, locked, realign_cnt);
                end
            end
            if (i == 83) begin
                cmps++;
                if ({locked, realign_cnt} !== {1'b0, 8'd1}) begin
                    errs++; $display("FAIL slip_unlock: got %b %0d want 0 1", locked, realign_cnt);
                end
            end
            if (i == 113) begin
                cmps++;
                if ({locked, realign_cnt} !== {1'b1, 8'd1}) begin
                    errs++; $display("FAIL slip_relock: got %b %0d want 1 1", locked, realign_cnt);
                end
            end
        end
    endtask

    task automatic test_stray_comma();
        dut_reset();
        q.delete();
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        push_word(CN); push_word(10'h2AA); push_word(CP); push_word(CN);
        q.push_back(1'b0);
        push_word(CP);
        for (int i = 0; i < 9; i++) q.push_back(i % 2 == 1);
        push_word(CN);
        q.push_back(1'b0);
        push_word(CP); push_word(CN); push_word(CP);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL stray[%0d]: got %h want %h", i, obs(), expv()); end
            if (i == 72) begin
                cmps++;
                if ({locked, sym_valid, is_comma, sym, realign_cnt} !== {3'b111, CN, 8'd0}) begin
                    errs++; $display("FAIL stray_aligned: got %b%b%b %h %0d want 111 %h 0", locked, sym_valid, is_comma, sym, realign_cnt, CN);
                end
            end
            if (i == 103) begin
                cmps++;
                if ({locked, realign_cnt} !== {1'b1, 8'd0}) begin
                    errs++; $display("FAIL stray_cleared: got %b %0d want 1 0", locked, realign_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        int r, i;
        logic v;
        dut_reset();
        q.delete();
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r < 4) push_word(r[0] ? CN : CP);
            else if (r < 8) push_word(10'($urandom));
            else repeat ($urandom_range(1, 3)) q.push_back(1'($urandom));
        end
        i = 0;
        while (i < q.size()) begin
            v = $urandom_range(0, 3) != 0;
            step(v, v ? q[i] : 1'($urandom));
            if (v) i++;
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv()); end
        end
    endtask

    task automatic test_saturation();
        dut_reset();
        q.delete();
        repeat (260) begin
            push_word(CN); push_word(CP); push_word(CN);
            q.push_back(1'b0);
            push_word(CP); push_word(CN); push_word(CP); push_word(CN);
        end
        for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            cmps++;
            if (obs() !== expv()) begin errs++; $display("FAIL sat[%0d]: got %h want %h", i, obs(), expv()); end
        end
        cmps++;
        if (realign_cnt !== 8'hFF) begin errs++; $display("FAIL sat_final: got %h want ff", realign_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gapped();
        test_bit_slip();
        test_stray_comma();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
